rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters.
  - Requester 0: in-order pipeline writeback (ALU/load).
  - Requester 1: long-latency unit (mul/div).
- Drives the register file's write-enable, destination and data from a registered output stage.
- Tracks which destinations the long-latency unit still owes, so decode can stall on RAW hazards.
- Sits between the execute/writeback stages and the register file.

---
 rtl/rf_ctrl_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 40 ++++
 rtl/rf_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-port control slice.
package rf_ctrl_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int XLEN_DEFAULT = 32;
  localparam int STARVE_W     = 4;

  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_LONG = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LONG = 2'd2
  } gnt_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination mask for the long-latency unit; drives WAW issue gating
// and RAW busy flags for decode.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  output logic                  o_issue_ready,
  input  logic                  i_retire_valid,
  input  logic [REG_ADDR_W-1:0] i_retire_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy
);
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set, w_clr;
  logic                w_issue_xfer;

  assign o_issue_ready = (i_issue_rd == '0) || !r_pending[i_issue_rd];
  assign w_issue_xfer  = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_issue_xfer)   w_set[i_issue_rd]  = 1'b1;
    if (i_retire_valid) w_clr[i_retire_rd] = 1'b1;
  end

  // A fresh issue wins over a retire of the same (non-pending) register.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= ((r_pending & ~w_clr) | w_set) & ~NUM_REGS'(1);
  end

  assign o_rs1_busy = (i_rs1 != '0) && r_pending[i_rs1];
  assign o_rs2_busy = (i_rs2 != '0) && r_pending[i_rs2];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: wb0 > wb1 with starvation override,
// registered write stage and long-latency scoreboard. Stats under RF_WB_STATS_EN.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int          XLEN         = XLEN_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [REG_ADDR_W-1:0] wb0_rd,
  input  logic [XLEN-1:0]       wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [REG_ADDR_W-1:0] wb1_rd,
  input  logic [XLEN-1:0]       wb1_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_write_data,
  output logic [31:0]           stat_wb0_cnt,
  output logic [31:0]           stat_wb1_cnt,
  output logic [31:0]           stat_stall_cnt
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0]   r_starve;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;
  logic                  w_force, w_xfer0, w_xfer1, w_stall;
  gnt_e                  w_gnt;

  // ready never looks at the requester's own rd/data, only valids and starve state
  assign w_force   = wb1_valid && (r_starve == LIMIT);
  assign wb0_ready = !w_force;
  assign wb1_ready = w_force || !wb0_valid;
  assign w_xfer0   = wb0_valid && wb0_ready;
  assign w_xfer1   = wb1_valid && wb1_ready;
  assign w_stall   = (wb0_valid && !wb0_ready) || (wb1_valid && !wb1_ready);

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_xfer1)      w_gnt = GNT_LONG;
    else if (w_xfer0) w_gnt = GNT_PIPE;
  end

  always_ff @(posedge clk) begin
    if (rst)                           r_starve <= '0;
    else if (wb1_valid && !wb1_ready)  r_starve <= (r_starve == LIMIT) ? r_starve : r_starve + 1'b1;
    else                               r_starve <= '0;
  end

  // rd/data follow any accepted write; x0 writes are simply not enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      case (w_gnt)
        GNT_PIPE: begin
          r_we   <= (wb0_rd != '0);
          r_rd   <= wb0_rd;
          r_data <= wb0_data;
        end
        GNT_LONG: begin
          r_we   <= (wb1_rd != '0);
          r_rd   <= wb1_rd;
          r_data <= wb1_data;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign rf_reg_write  = r_we;
  assign rf_rd         = r_rd;
  assign rf_write_data = r_data;

  rf_scoreboard u_sb (
    .clk            (clk),
    .rst            (rst),
    .i_issue_valid  (issue_valid),
    .i_issue_rd     (issue_rd),
    .o_issue_ready  (issue_ready),
    .i_retire_valid (w_xfer1),
    .i_retire_rd    (wb1_rd),
    .i_rs1          (rs1),
    .i_rs2          (rs2),
    .o_rs1_busy     (rs1_busy),
    .o_rs2_busy     (rs2_busy)
  );

`ifdef RF_WB_STATS_EN
  logic [31:0] r_stat0, r_stat1, r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
      r_stall <= '0;
    end else begin
      if (w_xfer0) r_stat0 <= sat_inc32(r_stat0);
      if (w_xfer1) r_stat1 <= sat_inc32(r_stat1);
      if (w_stall) r_stall <= sat_inc32(r_stall);
    end
  end

  assign stat_wb0_cnt   = r_stat0;
  assign stat_wb1_cnt   = r_stat1;
  assign stat_stall_cnt = r_stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
  assign stat_wb0_cnt   = '0;
  assign stat_wb1_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle reference model checks every
// output, plus hand-computed literal expectations for key scenarios.
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int LIM  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [4:0]      wb0_rd, wb1_rd, issue_rd, rs1, rs2, rf_rd;
  logic [XLEN-1:0] wb0_data, wb1_data, rf_write_data;
  logic            issue_valid, issue_ready, rs1_busy, rs2_busy, rf_reg_write;
  logic [31:0]     stat_wb0_cnt, stat_wb1_cnt, stat_stall_cnt;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .stat_wb0_cnt(stat_wb0_cnt), .stat_wb1_cnt(stat_wb1_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: blocked-streak counter, pending set, last accepted write
  int          m_streak;
  bit [31:0]   m_pend;
  bit          m_we, m_ok;
  bit [4:0]    m_rd;
  bit [31:0]   m_data;
  int unsigned m_s0, m_s1, m_ss;

  always @(negedge clk) begin
    bit force1, r0, r1, t0, t1, ir;
    force1 = wb1_valid && (m_streak >= LIM);
    r0 = !force1;
    r1 = force1 || !wb0_valid;
    t0 = wb0_valid && r0;
    t1 = wb1_valid && r1;
    ir = (issue_rd == 0) || !m_pend[issue_rd];
    if (m_ok) begin
      if (!rst) begin
        chk("wb0_ready", wb0_ready, r0);
        chk("wb1_ready", wb1_ready, r1);
        chk("issue_ready", issue_ready, ir);
        chk("rs1_busy", rs1_busy, (rs1 != 0) && m_pend[rs1]);
        chk("rs2_busy", rs2_busy, (rs2 != 0) && m_pend[rs2]);
      end
      chk("rf_reg_write", rf_reg_write, m_we);
      if (m_we) begin
        chk("rf_rd", rf_rd, m_rd);
        chk("rf_write_data", rf_write_data, m_data);
      end
`ifdef RF_WB_STATS_EN
      chk("stat_wb0", stat_wb0_cnt, m_s0);
      chk("stat_wb1", stat_wb1_cnt, m_s1);
      chk("stat_stall", stat_stall_cnt, m_ss);
`else
      chk("stat_wb0", stat_wb0_cnt, 0);
      chk("stat_wb1", stat_wb1_cnt, 0);
      chk("stat_stall", stat_stall_cnt, 0);
`endif
    end
    if (rst) begin
      m_ok = 1; m_streak = 0; m_pend = 0; m_we = 0; m_rd = 0; m_data = 0;
      m_s0 = 0; m_s1 = 0; m_ss = 0;
    end else begin
      if ((wb0_valid && !r0) || (wb1_valid && !r1)) m_ss++;
      if (t0) m_s0++;
      if (t1) m_s1++;
      m_streak = (wb1_valid && !r1) ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
      if (t1) m_pend[wb1_rd] = 1'b0;
      if (issue_valid && ir && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      m_we = 0;
      if (t1)      begin m_we = (wb1_rd != 0); m_rd = wb1_rd; m_data = wb1_data; end
      else if (t0) begin m_we = (wb0_rd != 0); m_rd = wb0_rd; m_data = wb0_data; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wb0_valid = 0; wb1_valid = 0; issue_valid = 0;
  endtask

  initial begin
    logic [9:0] pat;
    rst = 1; idle();
    wb0_rd = 0; wb1_rd = 0; wb0_data = 0; wb1_data = 0; issue_rd = 0; rs1 = 7; rs2 = 0;
    // reset with both requesters asserting
    wb0_valid = 1; wb1_valid = 1; wb0_rd = 3; wb1_rd = 4;
    tick(); tick();
    rst = 0; idle();
    tick();
    chk("rst_we", rf_reg_write, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_busy", rs1_busy, 0);

    // single wb0 write
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEADBEEF; #1;
    chk("wb0_rdy_lit", wb0_ready, 1);
    tick(); idle(); #1;
    chk("wb0_we_lit", rf_reg_write, 1);
    chk("wb0_rd_lit", rf_rd, 5);
    chk("wb0_data_lit", rf_write_data, 32'hDEADBEEF);

    // starvation: fresh reset so stats start at zero
    rst = 1; tick(); rst = 0;
    wb0_valid = 1; wb1_valid = 1; wb0_rd = 2; wb1_rd = 0; wb1_data = 32'h55;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      wb0_data = 32'h100 + i; #1;
      pat[i] = wb1_ready;
      if (i == 4 || i == 9) chk("force_wb0_rdy", wb0_ready, 0);
      tick();
    end
    chk("starve_pattern", {22'd0, pat}, 32'b1000010000);
    idle(); #1;
`ifdef RF_WB_STATS_EN
    chk("stat0_lit", stat_wb0_cnt, 8);
    chk("stat1_lit", stat_wb1_cnt, 2);
    chk("stall_lit", stat_stall_cnt, 10);
`else
    chk("stat0_off", stat_wb0_cnt, 0);
    chk("stat1_off", stat_wb1_cnt, 0);
    chk("stall_off", stat_stall_cnt, 0);
`endif
    tick();

    // scoreboard: issue x7, then retire it
    issue_valid = 1; issue_rd = 7; #1;
    chk("iss7_rdy_first", issue_ready, 1);
    tick(); issue_valid = 0; rs1 = 7; #1;
    chk("rs1_busy_lit", rs1_busy, 1);
    chk("iss7_waw", issue_ready, 0);
    wb1_valid = 1; wb1_rd = 7; wb1_data = 32'h12; issue_valid = 1; #1;
    chk("wb1_rdy_lit", wb1_ready, 1);
    chk("iss7_same_cyc", issue_ready, 0);
    tick(); idle(); #1;
    chk("rs1_clear_lit", rs1_busy, 0);
    chk("wb1_we_lit", rf_reg_write, 1);
    chk("wb1_rd_lit", rf_rd, 7);
    chk("wb1_data_lit", rf_write_data, 32'h12);

    // x0 handling
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'h99; issue_valid = 1; issue_rd = 0; #1;
    chk("x0_wb1_rdy", wb1_ready, 1);
    chk("x0_iss_rdy", issue_ready, 1);
    tick(); idle(); rs1 = 0; rs2 = 0; #1;
    chk("x0_we", rf_reg_write, 0);
    chk("x0_busy", rs1_busy, 0);

    // wb0 write to a pending destination leaves it pending
    issue_valid = 1; issue_rd = 9; tick(); idle();
    wb0_valid = 1; wb0_rd = 9; wb0_data = 32'hABC; rs2 = 9; tick(); idle(); #1;
    chk("wb0_pend_busy", rs2_busy, 1);
    chk("wb0_pend_we", rf_reg_write, 1);
    wb1_valid = 1; wb1_rd = 9; wb1_data = 32'h77; tick(); idle(); #1;
    chk("x9_retired", rs2_busy, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
